// File: rtl/freq_gate_ctrl.sv
// ---------------------------------------------------------------------------
// freq_gate_ctrl
//
// Purpose:
//   Sequencer for the frequency-measurement datapath. Opens a counting gate
//   of a fixed number of clock cycles, counts comparator rising-edge pulses
//   inside it, scales the count to Hz and offers the result downstream on a
//   valid/ready handshake. Supports single-shot and continuous measurement,
//   with abort.
//
// Optional feature:
//   AUTORANGE_EN - when defined, a low edge count switches the next gate to
//   2*GATE_CYCLES (with half the multiplier) and a high count switches it
//   back, with hysteresis. When undefined, range_long stays 0 and the gate
//   is always GATE_CYCLES.
//
// Ports:
//   clk_100kHz  in   system clock (100 kHz)
//   rst_        in   asynchronous active-high reset
//   start       in   single-cycle measurement request (ignored while busy)
//   continuous  in   re-arm automatically after each handshake
//   stop        in   abort the current measurement
//   edge_pulse  in   one-cycle pulse per comparator rising edge
//   freq_ready  in   downstream accepts the result
//   gate        out  counting window active
//   busy        out  sequencer not idle
//   freq_out    out  measured frequency in Hz (32 bit)
//   freq_valid  out  freq_out is valid
//   overflow    out  result saturated, qualified by freq_valid
//   range_long  out  current gate is 2*GATE_CYCLES
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module freq_gate_ctrl #(
  parameter int unsigned GATE_CYCLES = 50000,
  parameter logic [31:0] FREQ_MULT   = 32'd2,
  parameter int unsigned LOW_THRESH  = 16
) (
  input  logic        clk_100kHz,
  input  logic        rst_,
  input  logic        start,
  input  logic        continuous,
  input  logic        stop,
  input  logic        edge_pulse,
  input  logic        freq_ready,
  output logic        gate,
  output logic        busy,
  output logic [31:0] freq_out,
  output logic        freq_valid,
  output logic        overflow,
  output logic        range_long
);

`ifdef AUTORANGE_EN
  localparam bit AUTORANGE = 1'b1;
`else
  localparam bit AUTORANGE = 1'b0;
`endif

  localparam logic [31:0] GATE_LEN_SHORT = 32'(GATE_CYCLES);
  localparam logic [31:0] GATE_LEN_LONG  = 32'(2 * GATE_CYCLES);
  localparam logic [31:0] MULT_SHORT     = FREQ_MULT;
  localparam logic [31:0] MULT_LONG      = FREQ_MULT >> 1;
  localparam logic [31:0] THRESH_LO      = 32'(LOW_THRESH);
  localparam logic [31:0] THRESH_HI      = 32'(4 * LOW_THRESH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_GATE,
    ST_LATCH,
    ST_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] edge_cnt_q, edge_cnt_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] freq_out_q, freq_out_d;
  logic        freq_valid_q, freq_valid_d;
  logic        overflow_q, overflow_d;
  logic        range_long_q, range_long_d;
  logic [32:0] prod_sat;

  // Edge counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Full 64-bit product, clamped to 32 bits; MSB of the result flags
  // that clamping happened.
  function automatic logic [32:0] sat_mul(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    if (p[63:32] != 32'd0) begin
      return {1'b1, 32'hFFFF_FFFF};
    end
    return {1'b0, p[31:0]};
  endfunction

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    freq_out_d   = freq_out_q;
    freq_valid_d = freq_valid_q;
    overflow_d   = overflow_q;
    range_long_d = range_long_q;
    prod_sat     = sat_mul(edge_cnt_q, range_long_q ? MULT_LONG : MULT_SHORT);

    case (state_q)
      ST_IDLE: begin
        // stop wins so an abort held high keeps the block parked
        if (!stop && (start || continuous)) begin
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          edge_cnt_d = 32'd0;
          cyc_cnt_d  = (range_long_q ? GATE_LEN_LONG : GATE_LEN_SHORT) - 32'd1;
          state_d    = ST_GATE;
        end
      end

      ST_GATE: begin
        // Abort takes priority over the terminal count; the partial
        // count is simply discarded.
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          if (edge_pulse) begin
            edge_cnt_d = sat_inc(edge_cnt_q);
          end
          if (cyc_cnt_q == 32'd0) begin
            state_d = ST_LATCH;
          end else begin
            cyc_cnt_d = cyc_cnt_q - 32'd1;
          end
        end
      end

      ST_LATCH: begin
        freq_out_d   = prod_sat[31:0];
        overflow_d   = prod_sat[32];
        freq_valid_d = 1'b1;
        // Hysteresis band: only leave a range when clearly outside it.
        if (AUTORANGE) begin
          if (edge_cnt_q < THRESH_LO) begin
            range_long_d = 1'b1;
          end else if (edge_cnt_q >= THRESH_HI) begin
            range_long_d = 1'b0;
          end
        end
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        // stop is deliberately ignored: a produced result is always delivered
        if (freq_ready) begin
          freq_valid_d = 1'b0;
          state_d      = continuous ? ST_ARM : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100kHz or posedge rst_) begin
    if (rst_) begin
      state_q      <= ST_IDLE;
      edge_cnt_q   <= 32'd0;
      cyc_cnt_q    <= 32'd0;
      freq_out_q   <= 32'd0;
      freq_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      range_long_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      freq_out_q   <= freq_out_d;
      freq_valid_q <= freq_valid_d;
      overflow_q   <= overflow_d;
      range_long_q <= range_long_d;
    end
  end

  assign gate       = (state_q == ST_GATE);
  assign busy       = (state_q != ST_IDLE);
  assign freq_out   = freq_out_q;
  assign freq_valid = freq_valid_q;
  assign overflow   = overflow_q;
  assign range_long = range_long_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_freq_gate_ctrl
//
// Self-checking bench for freq_gate_ctrl. A main instance with a short gate
// exercises reset, single shot, boundary edges, handshake hold, continuous
// mode and abort; its results go through a scoreboard queue. A second
// instance with a tiny gate and a huge multiplier exercises saturation and
// auto-range. Works with or without AUTORANGE_EN defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_freq_gate_ctrl;

  localparam int unsigned G1 = 200;
  localparam logic [31:0] M1 = 32'd2;
  localparam int unsigned G2 = 4;
  localparam logic [31:0] M2 = 32'h8000_0000;
  localparam int unsigned LT = 16;

`ifdef AUTORANGE_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_;
  logic        start, continuous, stop, edge_pulse, freq_ready;
  logic        gate, busy, freq_valid, overflow, range_long;
  logic [31:0] freq_out;

  logic        start2, continuous2, stop2, edge2, ready2;
  logic        gate2, busy2, valid2, overflow2, range_long2;
  logic [31:0] freq_out2;

  freq_gate_ctrl #(.GATE_CYCLES(G1), .FREQ_MULT(M1), .LOW_THRESH(LT)) dut (
    .clk_100kHz(clk), .rst_(rst_), .start(start), .continuous(continuous),
    .stop(stop), .edge_pulse(edge_pulse), .freq_ready(freq_ready),
    .gate(gate), .busy(busy), .freq_out(freq_out), .freq_valid(freq_valid),
    .overflow(overflow), .range_long(range_long)
  );

  freq_gate_ctrl #(.GATE_CYCLES(G2), .FREQ_MULT(M2), .LOW_THRESH(LT)) dut_sat (
    .clk_100kHz(clk), .rst_(rst_), .start(start2), .continuous(continuous2),
    .stop(stop2), .edge_pulse(edge2), .freq_ready(ready2),
    .gate(gate2), .busy(busy2), .freq_out(freq_out2), .freq_valid(valid2),
    .overflow(overflow2), .range_long(range_long2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act,
                           input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference model
  bit rl1 = 1'b0;
  bit rl2 = 1'b0;

  function automatic int unsigned glen(input bit rl, input int unsigned g);
    return (AR && rl) ? 2 * g : g;
  endfunction

  function automatic logic [32:0] expect_res(input logic [31:0] cnt,
                                             input logic [31:0] m,
                                             input bit rl);
    logic [31:0]     mm;
    longint unsigned p;
    mm = (AR && rl) ? m / 2 : m;
    p  = 64'(cnt) * 64'(mm);
    if (p > 64'h0000_0000_FFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, p[31:0]};
  endfunction

  function automatic bit next_rl(input bit rl, input logic [31:0] cnt);
    if (!AR) return 1'b0;
    if (cnt < 32'(LT)) return 1'b1;
    if (cnt >= 32'(4 * LT)) return 1'b0;
    return rl;
  endfunction

  // Scoreboard: expectations pushed when a gate completes, popped on handshake
  logic [32:0] sb_q[$];
  logic [32:0] sb_exp;

  always @(negedge clk) begin
    if (rst_ === 1'b0 && freq_valid === 1'b1 && freq_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_result", 64'd1, 64'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check_val("sb_freq_out", 64'(freq_out), 64'(sb_exp[31:0]));
        check_val("sb_overflow", 64'(overflow), 64'(sb_exp[32]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_meas;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("arm_busy", 64'(busy), 64'd1);
    check_val("arm_gate", 64'(gate), 64'd0);
  endtask

  // Entered with the DUT in ARM. boundary=1 puts edges in ARM, the last
  // gate cycle and LATCH. stop_at>=0 aborts at that gate cycle.
  task automatic do_gate(input int n_edges, input bit boundary, input int stop_at);
    int unsigned gl;
    int          hi;
    logic [31:0] cnt;
    gl = glen(rl1, G1);
    hi = 0;
    edge_pulse = boundary;
    tick();
    edge_pulse = 1'b0;
    for (int i = 0; i < int'(gl); i++) begin
      if (i == stop_at) begin
        stop = 1'b1;
        continuous = 1'b0;
        tick();
        stop = 1'b0;
        check_val("stop_busy", 64'(busy), 64'd0);
        check_val("stop_gate", 64'(gate), 64'd0);
        check_val("stop_valid", 64'(freq_valid), 64'd0);
        return;
      end
      if (gate) hi++;
      edge_pulse = boundary ? (i == int'(gl) - 1) : (i < n_edges);
      tick();
    end
    edge_pulse = boundary;
    check_val("gate_len", 64'(hi), 64'(gl));
    check_val("latch_gate", 64'(gate), 64'd0);
    check_val("latch_valid", 64'(freq_valid), 64'd0);
    cnt = boundary ? 32'd1 : 32'(n_edges);
    sb_q.push_back(expect_res(cnt, M1, rl1));
    rl1 = next_rl(rl1, cnt);
    tick();
    edge_pulse = 1'b0;
    check_val("hold_valid", 64'(freq_valid), 64'd1);
    check_val("range_long", 64'(range_long), 64'(rl1));
  endtask

  logic [32:0] hold_exp;
  logic [32:0] sat_exp;
  int unsigned gl2;
  int          ne2;

  initial begin
    rst_ = 1'b1;
    start = 1'b0; continuous = 1'b0; stop = 1'b0; edge_pulse = 1'b0; freq_ready = 1'b0;
    start2 = 1'b0; continuous2 = 1'b0; stop2 = 1'b0; edge2 = 1'b0; ready2 = 1'b1;
    repeat (3) tick();
    check_val("rst_gate", 64'(gate), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_freq_out", 64'(freq_out), 64'd0);
    check_val("rst_valid", 64'(freq_valid), 64'd0);
    check_val("rst_overflow", 64'(overflow), 64'd0);
    check_val("rst_range_long", 64'(range_long), 64'd0);
    rst_ = 1'b0;
    tick();

    // Reset in the middle of a gate after 10 edges
    start_meas();
    tick();
    for (int i = 0; i < 20; i++) begin
      edge_pulse = (i < 10);
      tick();
    end
    edge_pulse = 1'b0;
    #2 rst_ = 1'b1;
    #1;
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_gate", 64'(gate), 64'd0);
    check_val("midrst_valid", 64'(freq_valid), 64'd0);
    check_val("midrst_freq_out", 64'(freq_out), 64'd0);
    tick();
    rst_ = 1'b0;
    tick();

    // Single shot, 100 edges, ready held high
    freq_ready = 1'b1;
    start_meas();
    do_gate(100, 1'b0, -1);
    tick();
    check_val("single_valid_1cyc", 64'(freq_valid), 64'd0);
    check_val("single_idle", 64'(busy), 64'd0);

    // Boundary edges: ARM, last gate cycle, LATCH
    start_meas();
    do_gate(0, 1'b1, -1);
    tick();
    check_val("bound_valid_1cyc", 64'(freq_valid), 64'd0);
    check_val("bound_idle", 64'(busy), 64'd0);

    // Handshake hold with ignored start pulses
    freq_ready = 1'b0;
    start_meas();
    do_gate(100, 1'b0, -1);
    hold_exp = sb_q[sb_q.size() - 1];
    for (int i = 0; i < 20; i++) begin
      start = (i % 5 == 0);
      tick();
      check_val("hold_valid_stable", 64'(freq_valid), 64'd1);
      check_val("hold_out_stable", 64'(freq_out), 64'(hold_exp[31:0]));
    end
    start = 1'b0;
    freq_ready = 1'b1;
    tick();
    freq_ready = 1'b0;
    check_val("hold_release_valid", 64'(freq_valid), 64'd0);
    check_val("hold_release_idle", 64'(busy), 64'd0);

    // Continuous back-to-back, then abort
    freq_ready = 1'b1;
    continuous = 1'b1;
    tick();
    check_val("cont_arm_busy", 64'(busy), 64'd1);
    do_gate(50, 1'b0, -1);
    tick();
    check_val("b2b_arm_busy", 64'(busy), 64'd1);
    check_val("b2b_arm_gate", 64'(gate), 64'd0);
    check_val("b2b_arm_valid", 64'(freq_valid), 64'd0);
    do_gate(50, 1'b0, -1);
    tick();
    check_val("b2b2_arm_busy", 64'(busy), 64'd1);
    do_gate(30, 1'b0, 100);
    repeat (3) tick();
    check_val("abort_stays_idle", 64'(busy), 64'd0);
    check_val("abort_no_valid", 64'(freq_valid), 64'd0);

    // Saturation / auto-range on the small-gate instance
    for (int run = 0; run < 2; run++) begin
      gl2 = glen(rl2, G2);
      ne2 = (run == 0) ? 3 : 2;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      tick();
      for (int i = 0; i < int'(gl2); i++) begin
        edge2 = (i < ne2);
        tick();
      end
      edge2 = 1'b0;
      check_val("sat_latch_gate", 64'(gate2), 64'd0);
      tick();
      sat_exp = expect_res(32'(ne2), M2, rl2);
      rl2 = next_rl(rl2, 32'(ne2));
      check_val("sat_valid", 64'(valid2), 64'd1);
      check_val("sat_freq_out", 64'(freq_out2), 64'(sat_exp[31:0]));
      check_val("sat_overflow", 64'(overflow2), 64'(sat_exp[32]));
      check_val("sat_range_long", 64'(range_long2), 64'(rl2));
      tick();
      check_val("sat_valid_clear", 64'(valid2), 64'd0);
    end

    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
